reg_file_writer: RTL and testbench
==================================

Name: reg_file_writer

Overview:
Write side of the 8 x 32-bit register file. It accepts single-word writes and sequential fill bursts, then holds the register contents. Its eight register outputs drive the from_reg0..from_reg7 inputs of read_operation. A small FSM sequences fill bursts, and a valid-mask tracks which registers hold written data.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 3, address width; register count = 2**ADDR_W = 8

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
we  input  1  single-word write strobe
wAddr  input  3  write address for we
wData  input  32  write data for we
fill_start  input  1  start fill burst (pulse)
fill_addr  input  3  first register of burst
fill_len  input  3  burst length minus 1 (0 -> 1 word, 7 -> 8 words)
fill_data  input  32  starting data value for burst
fill_incr  input  1  1: data increments by 1 per word; 0: constant data
busy  output  1  fill burst in progress
done  output  1  one-cycle pulse after the last burst word is written
valid  output  8  bit i = register i written since reset
reg0..reg7  output  32 each  register contents (to read_operation from_reg0..7)

Behaviour:
- Reset (reset_n low, async): reg0..reg7 = 0, valid = 0, busy = 0, done = 0, FSM -> IDLE. Reset mid-burst aborts the burst immediately; there is no partial-completion report.
- All state updates on rising clk; every output is a registered value.
- Single write: in IDLE with we = 1, reg[wAddr] <= wData and valid[wAddr] <= 1. New value is visible on the next edge (latency 1).
- FSM states: IDLE, FILL, DONE.
- IDLE -> FILL on fill_start = 1. Capture fill_addr, fill_len, fill_data and fill_incr into internal regs (cur_addr, remaining, cur_data, incr). busy <= 1.
- If fill_start and we are both high in IDLE: fill_start wins and the we write is dropped.
- FILL, every cycle:
  - reg[cur_addr] <= cur_data; valid[cur_addr] <= 1
  - cur_addr <= cur_addr + 1, mod 8 (wraps 7 -> 0)
  - cur_data <= cur_data + incr, mod 2^32 (wraps FFFF_FFFF -> 0)
  - remaining decrements each cycle
  - When remaining == 0 in FILL -> DONE.
- DONE: busy <= 0, done <= 1 for exactly one cycle, then -> IDLE.
- Burst latency: N = fill_len + 1 words written over N cycles after the start edge. The done pulse follows the last write by 1 cycle.
- During FILL and DONE, we and fill_start are ignored (no queueing).
- fill_len = 7 with a nonzero fill_addr wraps and covers all 8 registers exactly once.
- valid bits are never cleared except by reset.

Decomposition:
- Shared package rf_pkg:
  - DATA_W, ADDR_W, NUM_REGS = 8
  - state encoding IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2
  - shared by read_operation and its benches
- One natural sub-module: rf_write_decoder, a 3-to-8 one-hot decoder with enable. It produces per-register load enables from the muxed address (wAddr in IDLE, cur_addr in FILL).

Test Plan:
1. Reset check: assert reset_n = 0 asynchronously mid-cycle -> reg0..reg7 = 0, valid = 8'h00, busy = 0 immediately, without waiting for a clock edge.
2. Single-write sweep:
   - stimulus: we = 1, wAddr = 0..7 with wData = 32'h0, 0000_0001, 0000_0011, …, 0111_1111 on successive edges
   - response: regN equals the matching value one edge later; valid = 8'hFF after the 8th edge
   - read_operation fed from reg0..7 returns the same values per Addr.
3. Incrementing burst with wrap:
   - stimulus: fill_addr = 6, fill_len = 3, fill_data = 32'hFFFF_FFFE, fill_incr = 1
   - response: reg6 = FFFF_FFFE, reg7 = FFFF_FFFF, reg0 = 0, reg1 = 1; busy high 4 cycles; done pulses once on cycle 5.
4. Constant full fill: fill_addr = 3, fill_len = 7, fill_data = 32'hA5A5_A5A5, fill_incr = 0 -> all 8 regs = A5A5_A5A5 after 8 cycles; no register written twice.
5. Priority and collision:
   - fill_start = 1 and we = 1 (wAddr = 2, wData = 32'h1234) in the same IDLE cycle -> the burst runs and reg2 does not get 32'h1234
   - we asserted during FILL -> ignored.
6. Reset mid-burst: assert reset_n = 0 in the 2nd cycle of an 8-word burst -> all regs = 0, FSM = IDLE, done never pulses; a fresh single write after release works normally.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the 8 x 32-bit register file (write side and
// read_operation). Widths live here so both sides agree on them.
package rf_pkg;

    localparam int DATA_W   = 32;              // register width in bits
    localparam int ADDR_W   = 3;               // register address width
    localparam int NUM_REGS = 1 << ADDR_W;     // 8 registers

    // Fill-burst sequencer state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/rf_write_decoder.sv
// One-hot load-enable decoder: turns the selected write address into a
// per-register load strobe, all zero when no write is happening.
module rf_write_decoder
    import rf_pkg::*;
(
    input  logic                en,
    input  logic [ADDR_W-1:0]   addr,
    output logic [NUM_REGS-1:0] onehot
);

    // At most one register loads per cycle
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_writer.sv
// Write side of the 8 x 32-bit register file. Accepts single-word writes
// in IDLE and sequential fill bursts driven by a small FSM, then holds the
// register contents for read_operation. valid[i] records that register i
// has been written since reset.
//
// Fill protocol: fill_start is a one-cycle request sampled only in IDLE
// (it wins over a same-cycle we). busy is high from the edge that accepts
// the request until the edge of the last burst write; done pulses for the
// single cycle that follows that last write. Requests and we strobes that
// arrive while busy or done are dropped, not queued.
module reg_file_writer
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   wAddr,
    input  logic [DATA_W-1:0]   wData,
    input  logic                fill_start,
    input  logic [ADDR_W-1:0]   fill_addr,
    input  logic [ADDR_W-1:0]   fill_len,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic                fill_incr,
    output logic                busy,
    output logic                done,
    output logic [NUM_REGS-1:0] valid,
    output logic [1:0]          state,
    output logic [DATA_W-1:0]   reg0,
    output logic [DATA_W-1:0]   reg1,
    output logic [DATA_W-1:0]   reg2,
    output logic [DATA_W-1:0]   reg3,
    output logic [DATA_W-1:0]   reg4,
    output logic [DATA_W-1:0]   reg5,
    output logic [DATA_W-1:0]   reg6,
    output logic [DATA_W-1:0]   reg7
);

    logic [1:0]          state_q;
    logic [ADDR_W-1:0]   cur_addr;
    logic [ADDR_W-1:0]   remaining;
    logic [DATA_W-1:0]   cur_data;
    logic                incr;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] load_en;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    // Write-port mux: the burst owns the port in FILL, otherwise a single
    // write may use it unless a fill request is taking priority this cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wAddr;
        wr_data = wData;
        if (state_q == FILL) begin
            wr_en   = 1'b1;
            wr_addr = cur_addr;
            wr_data = cur_data;
        end else if (state_q == IDLE) begin
            wr_en   = we & ~fill_start;
        end
    end

    rf_write_decoder u_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (load_en)
    );

    // Burst sequencer: captures the request, walks the address/data
    // counters with natural wrap, and raises the done pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            cur_data  <= '0;
            incr      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_start) begin
                        cur_addr  <= fill_addr;
                        remaining <= fill_len;
                        cur_data  <= fill_data;
                        incr      <= fill_incr;
                        busy      <= 1'b1;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    cur_addr  <= cur_addr + ADDR_W'(1);
                    cur_data  <= cur_data + DATA_W'(incr);
                    remaining <= remaining - ADDR_W'(1);
                    if (remaining == '0) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Register storage and sticky written-since-reset mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            valid <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (load_en[i]) begin
                    regs[i] <= wr_data;
                end
            end
            valid <= valid | load_en;
        end
    end

    assign state = state_q;
    assign reg0  = regs[0];
    assign reg1  = regs[1];
    assign reg2  = regs[2];
    assign reg3  = regs[3];
    assign reg4  = regs[4];
    assign reg5  = regs[5];
    assign reg6  = regs[6];
    assign reg7  = regs[7];

endmodule

// File: tb/tb_reg_file_writer.sv
// Bench for reg_file_writer: directed single writes and fill bursts.
// Drivers push expected (address, data) writes into exp_q; a monitor pops
// one entry for every register whose value or valid bit changes.
module tb_reg_file_writer;
    import rf_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic        fill_start;
    logic [2:0]  fill_addr;
    logic [2:0]  fill_len;
    logic [31:0] fill_data;
    logic        fill_incr;
    logic        busy;
    logic        done;
    logic [7:0]  valid;
    logic [1:0]  state;
    logic [31:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;

    logic [31:0] rv [8];
    logic [31:0] prev_v [8];
    logic [7:0]  prev_valid;
    logic [34:0] exp_q [$];
    logic [34:0] item;

    int total = 0;
    int bad   = 0;

    reg_file_writer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_len   (fill_len),
        .fill_data  (fill_data),
        .fill_incr  (fill_incr),
        .busy       (busy),
        .done       (done),
        .valid      (valid),
        .state      (state),
        .reg0       (reg0),
        .reg1       (reg1),
        .reg2       (reg2),
        .reg3       (reg3),
        .reg4       (reg4),
        .reg5       (reg5),
        .reg6       (reg6),
        .reg7       (reg7)
    );

    assign rv[0] = reg0;
    assign rv[1] = reg1;
    assign rv[2] = reg2;
    assign rv[3] = reg3;
    assign rv[4] = reg4;
    assign rv[5] = reg5;
    assign rv[6] = reg6;
    assign rv[7] = reg7;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit
    initial begin
        #200000;
        $display("FAIL timeout: got=no finish exp=finish");
        $fatal(1, "time limit");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] regs_or();
        return reg0 | reg1 | reg2 | reg3 | reg4 | reg5 | reg6 | reg7;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) prev_v[i] = rv[i];
            prev_valid = valid;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (rv[i] !== prev_v[i] || valid[i] !== prev_valid[i]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: reg%0d got=%h exp=no write", i, rv[i]);
                    end else begin
                        item = exp_q.pop_front();
                        check("write_addr", 32'(i), 32'(item[34:32]));
                        check("write_data", rv[i], item[31:0]);
                        check("write_valid", 32'(valid[i]), 32'd1);
                    end
                end
            end
            for (int i = 0; i < 8; i++) prev_v[i] = rv[i];
            prev_valid = valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic [2:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
        we    = 1'b1;
        wAddr = a;
        wData = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        check("single_latency", rv[a], d);
    endtask

    task automatic run_burst(input logic [2:0] a, input logic [2:0] len, input logic [31:0] d,
                             input logic inc, input logic collide, input logic inject);
        int          busy_cnt;
        int          done_cnt;
        int          done_at;
        logic [2:0]  ea;
        logic [31:0] ed;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        ea = a;
        ed = d;
        for (int k = 0; k <= int'(len); k++) begin
            exp_q.push_back({ea, ed});
            ea = ea + 3'd1;
            ed = ed + 32'(inc);
        end
        fill_addr  = a;
        fill_len   = len;
        fill_data  = d;
        fill_incr  = inc;
        fill_start = 1'b1;
        if (collide) begin
            we    = 1'b1;
            wAddr = 3'd2;
            wData = 32'h0000_1234;
        end
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        we         = 1'b0;
        for (int c = 1; c <= int'(len) + 4; c++) begin
            @(negedge clk);
            if (c == 1) check("burst_state_fill", 32'(state), 32'(FILL));
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (inject && c == 2) begin
                we    = 1'b1;
                wAddr = 3'd0;
                wData = 32'hDEAD_BEEF;
            end
            if (inject && c == 5) we = 1'b0;
        end
        check("burst_busy_cycles", 32'(busy_cnt), 32'(int'(len) + 1));
        check("burst_done_count", 32'(done_cnt), 32'd1);
        check("burst_done_cycle", 32'(done_at), 32'(int'(len) + 2));
        check("burst_end_idle", 32'(state), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] v;
        int          done_seen;

        reset_n    = 1'b0;
        we         = 1'b0;
        wAddr      = '0;
        wData      = '0;
        fill_start = 1'b0;
        fill_addr  = '0;
        fill_len   = '0;
        fill_data  = '0;
        fill_incr  = 1'b0;

        // Power-on reset values
        #12;
        check("por_regs", regs_or(), 32'd0);
        check("por_valid", 32'(valid), 32'd0);
        check("por_busy", 32'(busy), 32'd0);
        check("por_done", 32'(done), 32'd0);
        check("por_state", 32'(state), 32'(IDLE));
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single-write sweep: 0, 1, 11, 111, ...
        v = 32'h0;
        for (int i = 0; i < 8; i++) begin
            write_word(3'(i), v);
            v = (v << 4) | 32'h1;
        end
        @(negedge clk);
        check("sweep_valid", 32'(valid), 32'h0000_00FF);
        check("sweep_reg7", reg7, 32'h0111_1111);
        check("sweep_reg3", reg3, 32'h0000_0111);

        // Asynchronous reset mid-cycle takes effect without a clock edge
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_regs", regs_or(), 32'd0);
        check("async_rst_valid", 32'(valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Incrementing burst with address and data wrap
        run_burst(3'd6, 3'd3, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        check("wrap_reg6", reg6, 32'hFFFF_FFFE);
        check("wrap_reg7", reg7, 32'hFFFF_FFFF);
        check("wrap_reg0", reg0, 32'h0000_0000);
        check("wrap_reg1", reg1, 32'h0000_0001);
        check("wrap_valid", 32'(valid), 32'h0000_00C3);

        // Constant full fill from a nonzero start
        run_burst(3'd3, 3'd7, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0);
        check("full_valid", 32'(valid), 32'h0000_00FF);
        check("full_reg2", reg2, 32'hA5A5_A5A5);

        // fill_start and we in the same IDLE cycle: burst wins
        run_burst(3'd2, 3'd1, 32'h0000_0055, 1'b1, 1'b1, 1'b0);
        check("collide_reg2", reg2, 32'h0000_0055);
        check("collide_reg3", reg3, 32'h0000_0056);

        // we held through FILL and DONE is ignored
        run_burst(3'd4, 3'd2, 32'h0000_0700, 1'b0, 1'b0, 1'b1);
        check("inject_reg0", reg0, 32'hA5A5_A5A5);
        check("inject_reg6", reg6, 32'h0000_0700);

        // Reset in the second cycle of an 8-word burst
        exp_q.push_back({3'd0, 32'h0000_0100});
        fill_addr  = 3'd0;
        fill_len   = 3'd7;
        fill_data  = 32'h0000_0100;
        fill_incr  = 1'b1;
        fill_start = 1'b1;
        @(posedge clk);
        #1 fill_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midburst_regs", regs_or(), 32'd0);
        check("midburst_valid", 32'(valid), 32'd0);
        check("midburst_busy", 32'(busy), 32'd0);
        check("midburst_state", 32'(state), 32'(IDLE));
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midburst_no_done", 32'(done_seen), 32'd0);
        check("midburst_idle_after", 32'(state), 32'(IDLE));

        // Normal single write after release
        write_word(3'd5, 32'hCAFE_F00D);
        @(negedge clk);
        check("post_rst_valid", 32'(valid), 32'h0000_0020);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
